// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bus responder.
// The read request travels down the read pipe so data can be fetched at drive time.
package sram_pkg;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam logic [SRAM_DATA_W-1:0] SRAM_OOR_DATA = 16'hDEAD;

  typedef struct packed {
    logic                   valid;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [1:0]             lane_n;  // {UB_N, LB_N} captured at issue
  } sram_rd_req_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sram_read_pipe.sv
// Read request delay line: a sample register followed by READ_LAT stages,
// so a read sampled at edge N reaches the head just after edge N+READ_LAT.
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  sram_rd_req_t req,
  output sram_rd_req_t head
);
  localparam int STAGES = READ_LAT;
  localparam int PW     = SRAM_ADDR_W + 2;

  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][PW-1:0] pay_pipe;

  // Only the valids are flushed; stale payload is harmless behind a cleared valid.
  always_ff @(posedge clk) begin
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-1:0], req.valid};
  end

  always_ff @(posedge clk) begin
    pay_pipe <= {pay_pipe[STAGES-1:0], req.addr, req.lane_n};
  end

  assign head = {vld_pipe[STAGES], pay_pipe[STAGES]};
endmodule

// File: rtl/sram_responder.sv
// Behavioural stand-in for the external 16-bit SRAM: byte-lane writes,
// latency-configurable reads, saturating access counters and a sticky range error.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        range_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]  mem [DEPTH];
  logic         active, wr_cyc, rd_cyc, in_rng;
  sram_rd_req_t req, head;
  logic         head_in_rng, drive;
  logic [15:0]  rd_data;

  // Accesses are ignored while reset is held.
  assign active = rst && !SRAM_CE_N;
  assign wr_cyc = active && !SRAM_WE_N;
  assign rd_cyc = active &&  SRAM_WE_N;
  assign in_rng = {1'b0, SRAM_ADDR} < 19'(DEPTH);

  always_ff @(posedge clk) begin
    if (wr_cyc && in_rng) begin
      if (!SRAM_LB_N) mem[SRAM_ADDR[AW-1:0]][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[SRAM_ADDR[AW-1:0]][15:8] <= SRAM_DQ[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_count  <= '0;
      rd_count  <= '0;
      range_err <= 1'b0;
    end else begin
      if (wr_cyc) wr_count <= sat_inc(wr_count);
      if (rd_cyc) rd_count <= sat_inc(rd_count);
      if (active && !in_rng) range_err <= 1'b1;
    end
  end

  assign req = {rd_cyc, SRAM_ADDR, SRAM_UB_N, SRAM_LB_N};

  sram_read_pipe #(.READ_LAT(READ_LAT)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .head (head)
  );

  // Array is read at drive time so a write just before the read is always seen.
  assign head_in_rng = {1'b0, head.addr} < 19'(DEPTH);
  assign rd_data     = head_in_rng ? mem[head.addr[AW-1:0]] : SRAM_OOR_DATA;
  assign drive       = head.valid && rst && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

  assign SRAM_DQ[15:8] = (drive && !head.lane_n[1]) ? rd_data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drive && !head.lane_n[0]) ? rd_data[7:0]  : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: three responders (READ_LAT 1/2/3) see identical bus traffic;
// the DQ nets are pulled high so a released bus reads back as all ones.
module tb_sram_responder;
  logic        clk, rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        tb_oe;
  logic [15:0] tb_dq;
  tri1  [15:0] dq1, dq2, dq3;
  logic [15:0] wrc1, rdc1, wrc2, rdc2, wrc3, rdc3;
  logic        rerr1, rerr2, rerr3;
  int          checks, passed, nwr, nrd;

  assign dq1 = tb_oe ? tb_dq : 16'hzzzz;
  assign dq2 = tb_oe ? tb_dq : 16'hzzzz;
  assign dq3 = tb_oe ? tb_dq : 16'hzzzz;

  sram_responder #(.DEPTH(1024), .READ_LAT(1)) u1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wrc1), .rd_count(rdc1), .range_err(rerr1));
  sram_responder #(.DEPTH(1024), .READ_LAT(2)) u2 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wrc2), .rd_count(rdc2), .range_err(rerr2));
  sram_responder #(.DEPTH(1024), .READ_LAT(3)) u3 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wrc3), .rd_count(rdc3), .range_err(rerr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus set up on the falling edge, results sampled 1 time unit after the rising edge.
  task automatic setbus(input logic [17:0] a, input logic ce, input logic we, input logic oe,
                        input logic ub, input logic lb, input logic drv, input logic [15:0] d);
    @(negedge clk);
    addr = a; ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb; tb_oe = drv; tb_dq = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    setbus(a, 1'b0, 1'b0, 1'b1, ub, lb, 1'b1, d);
    if (rst) nwr++;
  endtask

  task automatic rd(input logic [17:0] a, input logic ub, input logic lb);
    setbus(a, 1'b0, 1'b1, 1'b0, ub, lb, 1'b0, 16'h0000);
    if (rst) nrd++;
  endtask

  task automatic idle();
    setbus(18'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    rst = 1'b0; nwr = 0; nrd = 0;
    addr = '0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    tb_oe = 1'b0; tb_dq = '0;
    repeat (3) idle();
    checks++; if (wrc1 !== 16'd0) $display("FAIL reset_wr_count: got %h want 0000", wrc1); else passed++;
    checks++; if (rdc2 !== 16'd0) $display("FAIL reset_rd_count: got %h want 0000", rdc2); else passed++;
    checks++; if (rerr3 !== 1'b0) $display("FAIL reset_range_err: got %b want 0", rerr3); else passed++;
    checks++; if (dq1 !== 16'hFFFF) $display("FAIL reset_dq_released: got %h want ffff", dq1); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_word();
    wr(18'd5, 16'hA5C3, 1'b0, 1'b0);
    rd(18'd5, 1'b0, 1'b0);
    checks++; if (wrc1 !== 16'd1) $display("FAIL word_wr_count: got %h want 0001", wrc1); else passed++;
    checks++; if (rdc1 !== 16'd1) $display("FAIL word_rd_count: got %h want 0001", rdc1); else passed++;
    checks++; if (dq1 !== 16'hFFFF) $display("FAIL word_no_early_drive: got %h want ffff", dq1); else passed++;
    rd(18'd5, 1'b0, 1'b0);
    checks++; if (dq1 !== 16'hA5C3) $display("FAIL word_read_data: got %h want a5c3", dq1); else passed++;
  endtask

  task automatic test_byte_lanes();
    wr(18'd7, 16'h1234, 1'b0, 1'b0);
    wr(18'd7, 16'hABCD, 1'b1, 1'b0);
    rd(18'd7, 1'b0, 1'b0);
    rd(18'd7, 1'b0, 1'b1);
    checks++; if (dq1 !== 16'h12CD) $display("FAIL lane_merge: got %h want 12cd", dq1); else passed++;
    rd(18'd7, 1'b0, 1'b0);
    checks++; if (dq1 !== 16'h12FF) $display("FAIL lane_lower_z: got %h want 12ff", dq1); else passed++;
  endtask

  task automatic test_burst();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0003; exp_seq[3] = 16'h0004;
    for (int i = 0; i < 4; i++) wr(18'd8 + 18'(i), exp_seq[i], 1'b0, 1'b0);
    rd(18'd8, 1'b0, 1'b0);
    rd(18'd9, 1'b0, 1'b0);
    checks++; if (dq2 !== 16'hFFFF) $display("FAIL burst_latency_early: got %h want ffff", dq2); else passed++;
    for (int i = 0; i < 4; i++) begin
      rd((i < 2) ? 18'd10 + 18'(i) : 18'd8, 1'b0, 1'b0);
      checks++;
      if (dq2 !== exp_seq[i]) $display("FAIL burst_word%0d: got %h want %h", i, dq2, exp_seq[i]);
      else passed++;
    end
    checks++; if (wrc2 !== 16'(nwr)) $display("FAIL burst_wr_count: got %h want %h", wrc2, 16'(nwr)); else passed++;
    checks++; if (rdc2 !== 16'(nrd)) $display("FAIL burst_rd_count: got %h want %h", rdc2, 16'(nrd)); else passed++;
  endtask

  task automatic test_collision();
    rd(18'd3, 1'b0, 1'b0);
    @(negedge clk);
    addr = 18'd3; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    tb_oe = 1'b1; tb_dq = 16'h5A0F;
    @(posedge clk);
    nwr++;
    #1 tb_oe = 1'b0;
    #1;
    checks++; if (dq1 !== 16'hFFFF) $display("FAIL collision_no_drive: got %h want ffff", dq1); else passed++;
    checks++; if (dq2 !== 16'hFFFF) $display("FAIL collision_no_drive_l2: got %h want ffff", dq2); else passed++;
    rd(18'd3, 1'b0, 1'b0);
    checks++; if (rdc1 !== 16'(nrd)) $display("FAIL collision_rd_count: got %h want %h", rdc1, 16'(nrd)); else passed++;
    checks++; if (wrc1 !== 16'(nwr)) $display("FAIL collision_wr_count: got %h want %h", wrc1, 16'(nwr)); else passed++;
    rd(18'd3, 1'b0, 1'b0);
    checks++; if (dq1 !== 16'h5A0F) $display("FAIL collision_readback: got %h want 5a0f", dq1); else passed++;
  endtask

  task automatic test_out_of_range();
    checks++; if (rerr1 !== 1'b0) $display("FAIL oor_clear_before: got %b want 0", rerr1); else passed++;
    rd(18'd2000, 1'b0, 1'b0);
    rd(18'd5, 1'b0, 1'b0);
    checks++; if (dq1 !== 16'hDEAD) $display("FAIL oor_read_data: got %h want dead", dq1); else passed++;
    checks++; if (rerr1 !== 1'b1) $display("FAIL oor_flag_set: got %b want 1", rerr1); else passed++;
    rd(18'd5, 1'b0, 1'b0);
    idle();
    idle();
    checks++; if (rerr2 !== 1'b1) $display("FAIL oor_flag_sticky: got %b want 1", rerr2); else passed++;
    checks++; if (rdc1 !== 16'(nrd)) $display("FAIL oor_rd_count: got %h want %h", rdc1, 16'(nrd)); else passed++;
  endtask

  task automatic test_reset_mid_read();
    rd(18'd5, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; nwr = 0; nrd = 0;
    @(posedge clk);
    #1;
    checks++; if (rdc3 !== 16'd0) $display("FAIL midrst_rd_count: got %h want 0000", rdc3); else passed++;
    checks++; if (rerr3 !== 1'b0) $display("FAIL midrst_range_err: got %b want 0", rerr3); else passed++;
    for (int i = 0; i < 3; i++) begin
      rd(18'd5, 1'b0, 1'b0);
      checks++;
      if (dq3 !== 16'hFFFF) $display("FAIL midrst_dq_z%0d: got %h want ffff", i, dq3);
      else passed++;
    end
    checks++; if (wrc3 !== 16'd0) $display("FAIL midrst_wr_count: got %h want 0000", wrc3); else passed++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd(18'd5, 1'b0, 1'b0);
      checks++;
      if (dq3 !== 16'hFFFF) $display("FAIL postrst_flushed%0d: got %h want ffff", i, dq3);
      else passed++;
    end
    rd(18'd5, 1'b0, 1'b0);
    checks++; if (dq3 !== 16'hA5C3) $display("FAIL postrst_array_kept: got %h want a5c3", dq3); else passed++;
    checks++; if (rdc3 !== 16'(nrd)) $display("FAIL postrst_rd_count: got %h want %h", rdc3, 16'(nrd)); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    test_reset();
    test_word();
    test_byte_lanes();
    test_burst();
    test_collision();
    test_out_of_range();
    test_reset_mid_read();
    idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
